// File: rtl/gpio_wr_arbiter_pkg.sv
// gpio_pkg: shared definitions for the GPIO write arbiter.
//   state_e   - sequencer state encoding (IDLE / WRITE / HOLD)
//   GPIO_BASE - address of the GPIO/LED peripheral port served by this block
//   OWN_*     - requester identity, used for grant ownership and round-robin
package gpio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] GPIO_BASE = 32'hF000_0000;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/gpio_wr_arbiter_if.sv
// gpio_wr_arbiter_if: request/grant handshakes of the two writers plus the
// write strobe, data bus and status outputs toward the GPIO device.
//   master - requester side (CPU store path, debug writer, observers)
//   slave  - arbiter side
interface gpio_wr_arbiter_if;

  logic        cpu_req;
  logic [31:0] cpu_wdata;
  logic        dbg_req;
  logic [31:0] dbg_wdata;
  logic        cpu_gnt;
  logic        dbg_gnt;
  logic        GPIOf0000000_we;
  logic [31:0] Peripheral_in;
  logic        busy;
  logic        last_owner;
  logic [7:0]  write_cnt;

  modport master (
    output cpu_req, cpu_wdata, dbg_req, dbg_wdata,
    input  cpu_gnt, dbg_gnt, GPIOf0000000_we, Peripheral_in,
           busy, last_owner, write_cnt
  );

  modport slave (
    input  cpu_req, cpu_wdata, dbg_req, dbg_wdata,
    output cpu_gnt, dbg_gnt, GPIOf0000000_we, Peripheral_in,
           busy, last_owner, write_cnt
  );

endinterface

// File: rtl/gpio_wr_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req_i[0]     - CPU request,  req_i[1] - debug request
//   last_owner_i - owner of the previous grant
//   valid_o      - at least one request pending
//   winner_o     - OWN_CPU / OWN_DBG
module rr_arb2
  import gpio_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = OWN_CPU;
    if (req_i == 2'b11) begin
      // contention: whoever did not win last time goes now
      winner_o = ~last_owner_i;
    end else if (req_i[1]) begin
      winner_o = OWN_DBG;
    end
  end

endmodule

// File: rtl/gpio_wr_arbiter.sv
// gpio_wr_arbiter: shares the GPIO write strobe and data bus at GPIO_BASE
// between the CPU store path and a debug/pattern writer. One write per
// grant, then Peripheral_in is held stable for HOLD_CYCLES cycles.
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of gpio_wr_arbiter_if (requests in; grants, strobe,
//          data, busy, last_owner, write_cnt out)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a request; arbitrates and captures write data
//   ST_WRITE | one cycle: winner's gnt and we high
//   ST_HOLD  | data held stable, hold counter runs down to zero
module gpio_wr_arbiter
  import gpio_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input logic              clk,
  input logic              rst,
  gpio_wr_arbiter_if.slave bus
);

  // HOLD_CYCLES-1 is only meaningful when a hold window exists
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       pin_q;
  logic              we_q;
  logic              cpu_gnt_q;
  logic              dbg_gnt_q;
  logic              last_owner_q;
  logic [7:0]        write_cnt_q;

  logic              arb_valid;
  logic              arb_winner;

  rr_arb2 u_arb (
    .req_i        ({bus.dbg_req, bus.cpu_req}),
    .last_owner_i (last_owner_q),
    .valid_o      (arb_valid),
    .winner_o     (arb_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pin_q        <= '0;
      we_q         <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      // debug "owned" last, so the CPU wins the first contention
      last_owner_q <= OWN_DBG;
      write_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q      <= ST_WRITE;
            we_q         <= 1'b1;
            last_owner_q <= arb_winner;
            cpu_gnt_q    <= (arb_winner == OWN_CPU);
            dbg_gnt_q    <= (arb_winner == OWN_DBG);
            pin_q        <= (arb_winner == OWN_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
          end
        end
        ST_WRITE: begin
          we_q        <= 1'b0;
          cpu_gnt_q   <= 1'b0;
          dbg_gnt_q   <= 1'b0;
          write_cnt_q <= write_cnt_q + 8'd1;
          if (HOLD_CYCLES != 0) begin
            cnt_q   <= HOLD_LOAD;
            state_q <= ST_HOLD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_gnt         = cpu_gnt_q;
  assign bus.dbg_gnt         = dbg_gnt_q;
  assign bus.GPIOf0000000_we = we_q;
  assign bus.Peripheral_in   = pin_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.last_owner      = last_owner_q;
  assign bus.write_cnt       = write_cnt_q;

endmodule

// File: tb/tb_gpio_wr_arbiter.sv
module tb_gpio_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_wr_arbiter_if bus_a ();
  gpio_wr_arbiter_if bus_b ();

  gpio_wr_arbiter #(.HOLD_CYCLES(2), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  gpio_wr_arbiter #(.HOLD_CYCLES(0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    logic        rst;
    logic        creq;
    logic [31:0] cdat;
    logic        dreq;
    logic [31:0] ddat;
    logic        e_cg;
    logic        e_dg;
    logic        e_we;
    logic [31:0] e_pin;
    logic        e_busy;
    logic        e_lo;
    logic [7:0]  e_wc;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic r, logic cr, logic [31:0] cd, logic dr, logic [31:0] dd,
                              logic cg, logic dg, logic we, logic [31:0] pin,
                              logic bsy, logic lo, logic [7:0] wc);
    vec_t v;
    v.rst = r; v.creq = cr; v.cdat = cd; v.dreq = dr; v.ddat = dd;
    v.e_cg = cg; v.e_dg = dg; v.e_we = we; v.e_pin = pin;
    v.e_busy = bsy; v.e_lo = lo; v.e_wc = wc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    bus_a.cpu_req = 0; bus_a.cpu_wdata = 0; bus_a.dbg_req = 0; bus_a.dbg_wdata = 0;
    bus_b.cpu_req = 0; bus_b.cpu_wdata = 0; bus_b.dbg_req = 0; bus_b.dbg_wdata = 0;

    //           rst cr cdat   dr ddat  | cg dg we pin    busy lo wc
    tbl[0]  = mk(1, 0, 0,     0, 0,      0, 0, 0, 0,     0, 1, 0);
    // single CPU write, busy for WRITE + 2 HOLD cycles
    tbl[1]  = mk(0, 1, 'hA5,  0, 0,      1, 0, 1, 'hA5,  1, 0, 0);
    tbl[2]  = mk(0, 0, 0,     0, 0,      0, 0, 0, 'hA5,  1, 0, 1);
    tbl[3]  = mk(0, 0, 0,     0, 0,      0, 0, 0, 'hA5,  1, 0, 1);
    tbl[4]  = mk(0, 0, 0,     0, 0,      0, 0, 0, 'hA5,  0, 0, 1);
    // debug write; CPU request rises during HOLD, granted 1 cycle after IDLE
    tbl[5]  = mk(0, 0, 0,     1, 'h5A,   0, 1, 1, 'h5A,  1, 1, 1);
    tbl[6]  = mk(0, 1, 'h33,  0, 0,      0, 0, 0, 'h5A,  1, 1, 2);
    tbl[7]  = mk(0, 1, 'h33,  0, 0,      0, 0, 0, 'h5A,  1, 1, 2);
    tbl[8]  = mk(0, 1, 'h33,  0, 0,      0, 0, 0, 'h5A,  0, 1, 2);
    tbl[9]  = mk(0, 1, 'h33,  0, 0,      1, 0, 1, 'h33,  1, 0, 2);
    tbl[10] = mk(0, 0, 0,     0, 0,      0, 0, 0, 'h33,  1, 0, 3);
    tbl[11] = mk(0, 0, 0,     0, 0,      0, 0, 0, 'h33,  1, 0, 3);
    // contention arriving in the last HOLD cycle: ignored, then DBG (CPU owned last)
    tbl[12] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h33,  0, 0, 3);
    tbl[13] = mk(0, 1, 'h11,  1, 'h22,   0, 1, 1, 'h22,  1, 1, 3);
    tbl[14] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h22,  1, 1, 4);
    tbl[15] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h22,  1, 1, 4);
    tbl[16] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h22,  0, 1, 4);
    tbl[17] = mk(0, 1, 'h11,  1, 'h22,   1, 0, 1, 'h11,  1, 0, 4);
    // reset in the WRITE cycle: aborted write not counted, last_owner back to DBG
    tbl[18] = mk(1, 1, 'h11,  1, 'h22,   0, 0, 0, 0,     0, 1, 0);
    // both held continuously: CPU, DBG, CPU, DBG, strobe every 4 cycles
    tbl[19] = mk(0, 1, 'h11,  1, 'h22,   1, 0, 1, 'h11,  1, 0, 0);
    tbl[20] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h11,  1, 0, 1);
    tbl[21] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h11,  1, 0, 1);
    tbl[22] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h11,  0, 0, 1);
    tbl[23] = mk(0, 1, 'h11,  1, 'h22,   0, 1, 1, 'h22,  1, 1, 1);
    tbl[24] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h22,  1, 1, 2);
    tbl[25] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h22,  1, 1, 2);
    tbl[26] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h22,  0, 1, 2);
    tbl[27] = mk(0, 1, 'h11,  1, 'h22,   1, 0, 1, 'h11,  1, 0, 2);
    tbl[28] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h11,  1, 0, 3);
    tbl[29] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h11,  1, 0, 3);
    tbl[30] = mk(0, 1, 'h11,  1, 'h22,   0, 0, 0, 'h11,  0, 0, 3);
    tbl[31] = mk(0, 1, 'h11,  1, 'h22,   0, 1, 1, 'h22,  1, 1, 3);
    tbl[32] = mk(0, 0, 0,     0, 0,      0, 0, 0, 'h22,  1, 1, 4);
    tbl[33] = mk(0, 0, 0,     0, 0,      0, 0, 0, 'h22,  1, 1, 4);
    tbl[34] = mk(0, 0, 0,     0, 0,      0, 0, 0, 'h22,  0, 1, 4);

    for (int i = 0; i < NV; i++) begin
      rst             = tbl[i].rst;
      bus_a.cpu_req   = tbl[i].creq;
      bus_a.cpu_wdata = tbl[i].cdat;
      bus_a.dbg_req   = tbl[i].dreq;
      bus_a.dbg_wdata = tbl[i].ddat;
      @(posedge clk); #1;
      chk($sformatf("row%0d cpu_gnt", i),    32'(bus_a.cpu_gnt),         32'(tbl[i].e_cg));
      chk($sformatf("row%0d dbg_gnt", i),    32'(bus_a.dbg_gnt),         32'(tbl[i].e_dg));
      chk($sformatf("row%0d we", i),         32'(bus_a.GPIOf0000000_we), 32'(tbl[i].e_we));
      chk($sformatf("row%0d pin", i),        bus_a.Peripheral_in,        tbl[i].e_pin);
      chk($sformatf("row%0d busy", i),       32'(bus_a.busy),            32'(tbl[i].e_busy));
      chk($sformatf("row%0d last_owner", i), 32'(bus_a.last_owner),      32'(tbl[i].e_lo));
      chk($sformatf("row%0d write_cnt", i),  32'(bus_a.write_cnt),       32'(tbl[i].e_wc));
    end

    // HOLD_CYCLES=0 build: strobe every 2nd cycle, busy only during WRITE
    bus_b.cpu_req   = 1'b1;
    bus_b.cpu_wdata = 32'h77;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("h0 we k%0d", k),   32'(bus_b.GPIOf0000000_we), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("h0 busy k%0d", k), 32'(bus_b.busy),            (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("h0 gnt k%0d", k),  32'(bus_b.cpu_gnt),         (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("h0 pin",       bus_b.Peripheral_in,   32'h77);
    chk("h0 write_cnt", 32'(bus_b.write_cnt),  32'd4);

    // 256 back-to-back writes on the fast build: counter wraps to 0
    rst = 1'b1;
    @(posedge clk); #1;
    chk("wrap reset cnt", 32'(bus_b.write_cnt), 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 512; e++) begin
      @(posedge clk); #1;
      if (e == 510) chk("wrap cnt 255",   32'(bus_b.write_cnt),       32'd255);
      if (e == 511) chk("wrap last we",   32'(bus_b.GPIOf0000000_we), 32'd1);
      if (e == 512) chk("wrap cnt 0",     32'(bus_b.write_cnt),       32'd0);
    end
    bus_b.cpu_req = 1'b0;
    chk("idle dut_a after reset busy", 32'(bus_a.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
